// File: rtl/exe_ctrl_pipe_if.sv
// Control-word bundle between decode and the DSP48E1 control pipe: ENABLE/FLUSH and the input word go in;
// the final-stage word, its valid flag and occupancy come out.
interface exe_ctrl_pipe_if #(
    parameter int OPMODE_W  = 7,
    parameter int ALUMODE_W = 4,
    parameter int NUM_CE    = 4,
    parameter int OCC_W     = 4
);
    logic                 ENABLE;
    logic                 FLUSH;
    logic                 VALID_IN;
    logic [OPMODE_W-1:0]  OPMODE;
    logic [ALUMODE_W-1:0] ALUMODE;
    logic [NUM_CE-1:0]    CE_IN;
    logic [OPMODE_W-1:0]  OPMODE_OUT;
    logic [ALUMODE_W-1:0] ALUMODE_OUT;
    logic [NUM_CE-1:0]    CE_OUT;
    logic                 VALID_OUT;
    logic [OCC_W-1:0]     OCCUPANCY;
    logic                 IDLE;

    modport slave (
        input  ENABLE, FLUSH, VALID_IN, OPMODE, ALUMODE, CE_IN,
        output OPMODE_OUT, ALUMODE_OUT, CE_OUT, VALID_OUT, OCCUPANCY, IDLE
    );

    modport master (
        output ENABLE, FLUSH, VALID_IN, OPMODE, ALUMODE, CE_IN,
        input  OPMODE_OUT, ALUMODE_OUT, CE_OUT, VALID_OUT, OCCUPANCY, IDLE
    );
endinterface

// File: rtl/exe_ctrl_pipe.sv
// DEPTH-stage DSP48E1 control-word delay line with valid tracking, flush and CE gating on bubbles.
// Latency DEPTH advancing edges; ENABLE = 0 stalls every stage, FLUSH kills all in-flight words.
module exe_ctrl_pipe #(
    parameter int DEPTH     = 1,
    parameter int OPMODE_W  = 7,
    parameter int ALUMODE_W = 4,
    parameter int NUM_CE    = 4,
    parameter int GATE_CE   = 1,
    parameter int OCC_W     = 4
) (
    input  logic           CLK,
    input  logic           RESET,
    exe_ctrl_pipe_if.slave ctrl
);

    if (DEPTH < 1 || DEPTH > 8 || (2 ** OCC_W) <= DEPTH) begin : g_param_err
        $fatal(1, "exe_ctrl_pipe: DEPTH must be 1..8 and 2**OCC_W must exceed DEPTH");
    end

    logic [DEPTH-1:0]     vld_q, vld_d, src_vld;
    logic [OPMODE_W-1:0]  op_q  [DEPTH];
    logic [OPMODE_W-1:0]  op_d  [DEPTH];
    logic [OPMODE_W-1:0]  src_op[DEPTH];
    logic [ALUMODE_W-1:0] alu_q  [DEPTH];
    logic [ALUMODE_W-1:0] alu_d  [DEPTH];
    logic [ALUMODE_W-1:0] src_alu[DEPTH];
    logic [NUM_CE-1:0]    ce_q  [DEPTH];
    logic [NUM_CE-1:0]    ce_d  [DEPTH];
    logic [NUM_CE-1:0]    src_ce[DEPTH];
    logic [OCC_W-1:0]     occ_q, occ_d;

    // Each stage's source: the inputs for stage 0, the previous stage otherwise.
    always_comb begin
        src_vld    = '0;
        src_vld[0] = ctrl.VALID_IN;
        src_op[0]  = ctrl.OPMODE;
        src_alu[0] = ctrl.ALUMODE;
        src_ce[0]  = ctrl.CE_IN;
        for (int i = 1; i < DEPTH; i++) begin
            src_vld[i] = vld_q[i-1];
            src_op[i]  = op_q[i-1];
            src_alu[i] = alu_q[i-1];
            src_ce[i]  = ce_q[i-1];
        end
    end

    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            op_d[i]  = op_q[i];
            alu_d[i] = alu_q[i];
            ce_d[i]  = ce_q[i];
        end
        if (ctrl.FLUSH) begin
            vld_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (GATE_CE != 0) begin
                    ce_d[i] = '0;
                end
            end
        end else if (ctrl.ENABLE) begin
            vld_d = src_vld;
            for (int i = 0; i < DEPTH; i++) begin
                // Bubbles leave OPMODE/ALUMODE untouched so the DSP input muxes never glitch.
                if (src_vld[i]) begin
                    op_d[i]  = src_op[i];
                    alu_d[i] = src_alu[i];
                    ce_d[i]  = src_ce[i];
                end else if (GATE_CE != 0) begin
                    ce_d[i] = '0;
                end else begin
                    ce_d[i] = src_ce[i];
                end
            end
        end
    end

    // Occupancy is the popcount of next-state valids, so it cannot overshoot or wrap.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(vld_d[i]);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                alu_q[i] <= '0;
                ce_q[i]  <= '0;
            end
        end else begin
            vld_q <= vld_d;
            occ_q <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= op_d[i];
                alu_q[i] <= alu_d[i];
                ce_q[i]  <= ce_d[i];
            end
        end
    end

    assign ctrl.OPMODE_OUT  = op_q[DEPTH-1];
    assign ctrl.ALUMODE_OUT = alu_q[DEPTH-1];
    assign ctrl.CE_OUT      = ce_q[DEPTH-1];
    assign ctrl.VALID_OUT   = vld_q[DEPTH-1];
    assign ctrl.OCCUPANCY   = occ_q;
    assign ctrl.IDLE        = (occ_q == '0);

endmodule

// File: tb/tb_exe_ctrl_pipe.sv
// Scoreboarded bench for exe_ctrl_pipe across DEPTH 2/3/4 and both CE gating modes.
module tb_exe_ctrl_pipe;

    typedef struct packed {
        logic [6:0] op;
        logic [3:0] alu;
        logic [3:0] ce;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   sel   = 0;

    logic       d_en = 1'b0, d_fl = 1'b0, d_v = 1'b0;
    logic [6:0] d_op = '0;
    logic [3:0] d_alu = '0, d_ce = '0;

    word_t exp_q[$];

    logic       m_vld, m_idle;
    logic [6:0] m_op;
    logic [3:0] m_alu, m_ce, m_occ;

    always #5 clk = ~clk;

    exe_ctrl_pipe_if if3 ();
    exe_ctrl_pipe_if if2g ();
    exe_ctrl_pipe_if if2n ();
    exe_ctrl_pipe_if if4 ();

`define TB_CONN(IFN, N) \
    assign IFN.ENABLE   = d_en && (sel == N); \
    assign IFN.FLUSH    = d_fl && (sel == N); \
    assign IFN.VALID_IN = d_v; \
    assign IFN.OPMODE   = d_op; \
    assign IFN.ALUMODE  = d_alu; \
    assign IFN.CE_IN    = d_ce;

    `TB_CONN(if3, 0)
    `TB_CONN(if2g, 1)
    `TB_CONN(if2n, 2)
    `TB_CONN(if4, 3)

    exe_ctrl_pipe #(.DEPTH(3), .GATE_CE(1)) u_d3  (.CLK(clk), .RESET(rst), .ctrl(if3.slave));
    exe_ctrl_pipe #(.DEPTH(2), .GATE_CE(1)) u_d2g (.CLK(clk), .RESET(rst), .ctrl(if2g.slave));
    exe_ctrl_pipe #(.DEPTH(2), .GATE_CE(0)) u_d2n (.CLK(clk), .RESET(rst), .ctrl(if2n.slave));
    exe_ctrl_pipe #(.DEPTH(4), .GATE_CE(1)) u_d4  (.CLK(clk), .RESET(rst), .ctrl(if4.slave));

    always_comb begin
        case (sel)
            1: begin
                m_vld = if2g.VALID_OUT; m_op = if2g.OPMODE_OUT; m_alu = if2g.ALUMODE_OUT;
                m_ce = if2g.CE_OUT; m_occ = if2g.OCCUPANCY; m_idle = if2g.IDLE;
            end
            2: begin
                m_vld = if2n.VALID_OUT; m_op = if2n.OPMODE_OUT; m_alu = if2n.ALUMODE_OUT;
                m_ce = if2n.CE_OUT; m_occ = if2n.OCCUPANCY; m_idle = if2n.IDLE;
            end
            3: begin
                m_vld = if4.VALID_OUT; m_op = if4.OPMODE_OUT; m_alu = if4.ALUMODE_OUT;
                m_ce = if4.CE_OUT; m_occ = if4.OCCUPANCY; m_idle = if4.IDLE;
            end
            default: begin
                m_vld = if3.VALID_OUT; m_op = if3.OPMODE_OUT; m_alu = if3.ALUMODE_OUT;
                m_ce = if3.CE_OUT; m_occ = if3.OCCUPANCY; m_idle = if3.IDLE;
            end
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge: present a word, queue its expected output if it will be
    // captured, and return at the following negedge.
    task automatic drive(input logic en, input logic fl, input logic v,
                         input logic [6:0] op, input logic [3:0] alu, input logic [3:0] ce);
        d_en = en; d_fl = fl; d_v = v; d_op = op; d_alu = alu; d_ce = ce;
        if (en && !fl && v && !rst) exp_q.push_back({op, alu, ce});
        @(negedge clk);
    endtask

    task automatic switch_to(input int n);
        d_en = 1'b0; d_fl = 1'b0; d_v = 1'b0;
        sel = n;
        @(negedge clk);
    endtask

    // Monitor: a new word reaches the output only after an advancing edge.
    initial begin
        logic  adv;
        word_t w;
        forever begin
            @(posedge clk);
            adv = d_en && !d_fl && !rst;
            @(negedge clk);
            if (adv && m_vld) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_unexpected: got op=%h ce=%h, want no valid word", m_op, m_ce);
                end else begin
                    w = exp_q.pop_front();
                    chk("sb_word", {17'd0, m_op, m_alu, m_ce}, {17'd0, w});
                end
            end
        end
    end

    initial begin
        sel = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_vld", m_vld, 0);  chk("rst_occ", m_occ, 0); chk("rst_idle", m_idle, 1);
        chk("rst_ce", m_ce, 0);    chk("rst_op", m_op, 0);
        rst = 1'b0;

        // DEPTH 3: latency, ordering, stall, drain
        drive(1, 0, 1, 7'h05, 4'h1, 4'hF); chk("lat_occ1", m_occ, 1); chk("lat_vld1", m_vld, 0);
        drive(1, 0, 1, 7'h35, 4'h2, 4'h3); chk("lat_occ2", m_occ, 2); chk("lat_vld2", m_vld, 0);
        drive(1, 0, 1, 7'h25, 4'h3, 4'h8); chk("lat_occ3", m_occ, 3); chk("lat_op3", m_op, 7'h05);
        drive(1, 0, 1, 7'h11, 4'h4, 4'h1); chk("lat_occ4", m_occ, 3); chk("lat_op4", m_op, 7'h35);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 7'h7F, 4'hF, 4'hF);
            chk("stall_op", m_op, 7'h35); chk("stall_vld", m_vld, 1);
            chk("stall_occ", m_occ, 3);   chk("stall_ce", m_ce, 4'h3);
        end
        drive(1, 0, 1, 7'h22, 4'h5, 4'h2); chk("resume_op", m_op, 7'h25);
        drive(1, 0, 0, 7'h00, 4'h0, 4'hF); chk("drain_occ2", m_occ, 2); chk("drain_op1", m_op, 7'h11);
        drive(1, 0, 0, 7'h00, 4'h0, 4'hF); chk("drain_occ1", m_occ, 1); chk("drain_op2", m_op, 7'h22);
        drive(1, 0, 0, 7'h00, 4'h0, 4'hF);
        chk("drain_occ0", m_occ, 0); chk("drain_idle", m_idle, 1);
        chk("drain_vld", m_vld, 0);  chk("drain_ce", m_ce, 0); chk("drain_hold", m_op, 7'h22);
        chk("sb_empty_a", exp_q.size(), 0);

        // DEPTH 3: asynchronous reset between edges
        drive(1, 0, 1, 7'h0A, 4'h1, 4'hF);
        drive(1, 0, 1, 7'h0B, 4'h2, 4'hF);
        drive(1, 0, 1, 7'h0C, 4'h3, 4'hF);
        chk("pre_rst_occ", m_occ, 3);
        #2;
        rst = 1'b1; d_en = 1'b0; d_v = 1'b0;
        #1;
        chk("arst_vld", m_vld, 0); chk("arst_op", m_op, 0); chk("arst_alu", m_alu, 0);
        chk("arst_ce", m_ce, 0);   chk("arst_occ", m_occ, 0); chk("arst_idle", m_idle, 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 7'h00, 4'h0, 4'h0); chk("post_rst_occ", m_occ, 0);

        // DEPTH 2, CE gated on bubbles
        switch_to(1);
        drive(1, 0, 1, 7'h35, 4'h5, 4'hF);
        drive(1, 0, 0, 7'h00, 4'h0, 4'hF);
        drive(1, 0, 0, 7'h00, 4'h0, 4'hF);
        chk("gate_vld", m_vld, 0); chk("gate_ce", m_ce, 4'h0);
        chk("gate_op", m_op, 7'h35); chk("gate_alu", m_alu, 4'h5);
        chk("gate_occ", m_occ, 0);

        // DEPTH 2, CE passes through bubbles
        switch_to(2);
        drive(1, 0, 1, 7'h35, 4'h5, 4'hF);
        drive(1, 0, 0, 7'h00, 4'h0, 4'hA);
        drive(1, 0, 0, 7'h00, 4'h0, 4'hA);
        chk("nogate_vld", m_vld, 0); chk("nogate_ce", m_ce, 4'hA); chk("nogate_op", m_op, 7'h35);

        // DEPTH 4: flush wins over a stalled ENABLE and drops the presented word
        switch_to(3);
        for (int i = 1; i <= 4; i++) drive(1, 0, 1, 7'(i), 4'(i), 4'hF);
        chk("full_occ", m_occ, 4); chk("full_op", m_op, 7'h01);
        drive(0, 1, 1, 7'h66, 4'h6, 4'hF);
        exp_q.delete();
        chk("flush_occ", m_occ, 0); chk("flush_idle", m_idle, 1);
        chk("flush_vld", m_vld, 0); chk("flush_ce", m_ce, 0); chk("flush_op", m_op, 7'h01);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 7'h00, 4'h0, 4'hF);
        chk("post_flush_occ", m_occ, 0);
        drive(1, 0, 1, 7'h44, 4'h4, 4'hC);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 7'h00, 4'h0, 4'hF);
        chk("post_flush_vld", m_vld, 1); chk("post_flush_op", m_op, 7'h44);

        // DEPTH 2: continuous stream keeps occupancy pinned at 2, then drains
        switch_to(1);
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 1, 7'h40 + 7'(i), 4'(i), 4'hF);
            chk("stream_occ", m_occ, (i == 0) ? 1 : 2);
        end
        drive(1, 0, 0, 7'h00, 4'h0, 4'h0); chk("stream_occ1", m_occ, 1); chk("stream_busy", m_idle, 0);
        drive(1, 0, 0, 7'h00, 4'h0, 4'h0); chk("stream_occ0", m_occ, 0); chk("stream_idle", m_idle, 1);
        switch_to(1);
        chk("sb_empty_end", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

`undef TB_CONN

endmodule
